// File: rtl/secp256k1_inv_mod_ctrl.sv
// Fermat inverter sequencer for secp256k1: result = a^EXPONENT mod p using left-to-right
// square-and-multiply, issuing every product to an external shared serial multiplier.
module secp256k1_inv_mod_ctrl #(
    parameter logic [255:0] EXPONENT = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2D,
    parameter int unsigned  EXP_MSB  = 255
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] a,
    output logic         busy,
    output logic [255:0] result,
    output logic         done,
    output logic         mul_start,
    output logic [255:0] mul_a,
    output logic [255:0] mul_b,
    input  logic [255:0] mul_result,
    input  logic         mul_done
);

    typedef enum logic [2:0] {
        IDLE,
        SQ_ISSUE,
        SQ_WAIT,
        MUL_ISSUE,
        MUL_WAIT,
        FINISH
    } state_t;

    localparam logic [7:0] MSB_IDX = 8'(EXP_MSB);

    state_t       state_q, state_d;
    logic         busy_q, busy_d;
    logic         done_q, done_d;
    logic         mul_start_q, mul_start_d;
    logic [255:0] result_q, result_d;
    logic [255:0] mul_a_q, mul_a_d;
    logic [255:0] mul_b_q, mul_b_d;
    logic [255:0] acc_q, acc_d;
    logic [255:0] a_reg_q, a_reg_d;
    logic [7:0]   idx_q, idx_d;

    // Operands and mul_start are loaded on entry to an ISSUE state, so the pulse
    // is visible during the ISSUE cycle itself and each transaction costs 1 + latency.
    always_comb begin
        state_d     = state_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        mul_start_d = 1'b0;
        result_d    = result_q;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        acc_d       = acc_q;
        a_reg_d     = a_reg_q;
        idx_d       = idx_q;
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_reg_d = a;
                    acc_d   = a;
                    idx_d   = MSB_IDX;
                    busy_d  = 1'b1;
                    if (EXP_MSB == 0) begin
                        state_d = FINISH;
                    end else begin
                        state_d     = SQ_ISSUE;
                        mul_start_d = 1'b1;
                        mul_a_d     = a;
                        mul_b_d     = a;
                    end
                end
            end
            SQ_ISSUE: begin
                idx_d   = idx_q - 8'd1;
                state_d = SQ_WAIT;
            end
            SQ_WAIT: begin
                if (mul_done) begin
                    acc_d = mul_result;
                    if (EXPONENT[idx_q]) begin
                        state_d     = MUL_ISSUE;
                        mul_start_d = 1'b1;
                        mul_a_d     = mul_result;
                        mul_b_d     = a_reg_q;
                    end else if (idx_q == 8'd0) begin
                        state_d = FINISH;
                    end else begin
                        state_d     = SQ_ISSUE;
                        mul_start_d = 1'b1;
                        mul_a_d     = mul_result;
                        mul_b_d     = mul_result;
                    end
                end
            end
            MUL_ISSUE: begin
                state_d = MUL_WAIT;
            end
            MUL_WAIT: begin
                if (mul_done) begin
                    acc_d = mul_result;
                    if (idx_q == 8'd0) begin
                        state_d = FINISH;
                    end else begin
                        state_d     = SQ_ISSUE;
                        mul_start_d = 1'b1;
                        mul_a_d     = mul_result;
                        mul_b_d     = mul_result;
                    end
                end
            end
            FINISH: begin
                result_d = acc_q;
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        a_reg_q <= a_reg_d;
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            mul_start_q <= 1'b0;
            result_q    <= '0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            acc_q       <= '0;
            idx_q       <= '0;
        end else begin
            state_q     <= state_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            mul_start_q <= mul_start_d;
            result_q    <= result_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            acc_q       <= acc_d;
            idx_q       <= idx_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign mul_start = mul_start_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;

endmodule

// File: tb/tb_secp256k1_inv_mod_ctrl.sv
// Bench for secp256k1_inv_mod_ctrl with a behavioural mod-p multiplier of configurable latency.
module tb_secp256k1_inv_mod_ctrl;

    localparam logic [255:0] P    = 256'hFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFEFFFFFC2F;
    localparam logic [255:0] HALF = 256'h7FFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFFF7FFFFE18;

    logic         clk = 1'b0;
    logic         rst, start;
    logic [255:0] a;
    logic         busy, done, mul_start;
    logic [255:0] result, mul_a, mul_b;
    logic [255:0] mul_result = '0;
    logic         mul_done = 1'b0;

    int checks = 0;
    int errors = 0;

    int           fixed_lat = 0;
    int           lat_max = 4;
    int           n_mul_starts = 0;
    int           m_cnt = 0;
    int           m_lat;
    bit           outstanding = 1'b0;
    bit           opnd_changed = 1'b0;
    bit           overlap_err = 1'b0;
    logic [255:0] m_a = '0, m_b = '0;

    always #5 clk = ~clk;

    secp256k1_inv_mod_ctrl dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .a         (a),
        .busy      (busy),
        .result    (result),
        .done      (done),
        .mul_start (mul_start),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_result(mul_result),
        .mul_done  (mul_done)
    );

    function automatic logic [255:0] mulmod(input logic [255:0] x, input logic [255:0] y);
        logic [511:0] pr;
        pr = {256'd0, x} * {256'd0, y};
        pr = pr % {256'd0, P};
        return pr[255:0];
    endfunction

    // Multiplier model: mul_done rises m_lat cycles after the cycle mul_start is seen.
    always @(posedge clk) begin
        mul_done <= 1'b0;
        if (rst) begin
            outstanding <= 1'b0;
            m_cnt       <= 0;
        end else begin
            if (outstanding && (mul_a !== m_a || mul_b !== m_b)) opnd_changed <= 1'b1;
            if (mul_done) outstanding <= 1'b0;
            if (mul_start) begin
                if (outstanding) overlap_err <= 1'b1;
                m_lat = (fixed_lat > 0) ? fixed_lat : int'($urandom_range(lat_max, 1));
                m_a          <= mul_a;
                m_b          <= mul_b;
                outstanding  <= 1'b1;
                n_mul_starts <= n_mul_starts + 1;
                mul_result   <= mulmod(mul_a, mul_b);
                if (m_lat == 1) mul_done <= 1'b1;
                else m_cnt <= m_lat - 1;
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) mul_done <= 1'b1;
            end
        end
    end

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called on a negedge; start is high for that cycle (cycle 0). ncyc counts to the done cycle.
    task automatic run_op(input logic [255:0] av, input int inj, output logic [255:0] res,
                          output int ncyc, output int nst, output bit edge_ok, output bit pulse_ok);
        int s0;
        bit prev_busy;
        s0        = n_mul_starts;
        start     = 1'b1;
        a         = av;
        ncyc      = 0;
        prev_busy = 1'b0;
        while (ncyc < 8000) begin
            prev_busy = busy;
            @(negedge clk);
            ncyc++;
            start = (inj > 0 && ncyc == inj);
            if (start) a = av + 256'd1;
            if (done) break;
        end
        res     = result;
        nst     = n_mul_starts - s0;
        edge_ok = done && !busy && prev_busy;
        @(negedge clk);
        pulse_ok = !done;
    endtask

    logic [255:0] res, av;
    int           ncyc, nst, s0, waited;
    bit           eok, pok;

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", 256'(busy), 256'd0);
        chk("rst_done", 256'(done), 256'd0);
        chk("rst_mul_start", 256'(mul_start), 256'd0);
        chk("rst_result", result, 256'd0);
        chk("rst_mul_a", mul_a, 256'd0);
        chk("rst_mul_b", mul_b, 256'd0);

        run_op(256'd1, 0, res, ncyc, nst, eok, pok);
        chk("a1_result", res, 256'd1);
        chk("a1_mul_count", 256'(nst), 256'd503);
        chk("a1_busy_falls_with_done", 256'(eok), 256'd1);
        chk("a1_done_one_cycle", 256'(pok), 256'd1);

        run_op(256'd2, 0, res, ncyc, nst, eok, pok);
        chk("a2_result", res, HALF);

        run_op(P - 256'd1, 0, res, ncyc, nst, eok, pok);
        chk("pm1_result", res, P - 256'd1);

        run_op(256'd0, 0, res, ncyc, nst, eok, pok);
        chk("a0_result", res, 256'd0);
        chk("a0_mul_count", 256'(nst), 256'd503);

        for (int i = 0; i < 6; i++) begin
            av = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
            av = av % (P - 256'd1) + 256'd1;
            run_op(av, 0, res, ncyc, nst, eok, pok);
            chk($sformatf("rand%0d_a_times_inv", i), mulmod(av, res), 256'd1);
        end

        fixed_lat = 10;
        run_op(256'd2, 100, res, ncyc, nst, eok, pok);
        chk("lat10_done_cycle", 256'(ncyc), 256'd5535);
        chk("lat10_ignored_start_result", res, HALF);
        chk("lat10_mul_count", 256'(nst), 256'd503);

        s0     = n_mul_starts;
        start  = 1'b1;
        a      = 256'd5;
        waited = 0;
        while (n_mul_starts - s0 < 51 && waited < 2000) begin
            @(negedge clk);
            start = 1'b0;
            waited++;
        end
        chk("rst_test_reached_txn", 256'(n_mul_starts - s0), 256'd51);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 256'(busy), 256'd0);
        chk("midrst_done", 256'(done), 256'd0);
        chk("midrst_mul_start", 256'(mul_start), 256'd0);
        chk("midrst_result", result, 256'd0);
        rst       = 1'b0;
        fixed_lat = 0;
        run_op(256'd2, 0, res, ncyc, nst, eok, pok);
        chk("after_rst_a2_result", res, HALF);
        chk("after_rst_done_one_cycle", 256'(pok), 256'd1);

        chk("operands_stable", 256'(opnd_changed), 256'd0);
        chk("no_overlapping_mul_start", 256'(overlap_err), 256'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
